// File: rtl/power_mon_pkg.sv
// Shared definitions for the power monitor alarm stage: channel geometry,
// scan FSM encoding and the channel slice helper.
package power_mon_pkg;

    localparam int CH_NUM = 6;
    localparam int CH_W   = 16;
    localparam int CNT_W  = 4;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [CH_W-1:0] ch_slice(
        input logic [CH_NUM*CH_W-1:0] word,
        input logic [IDX_W-1:0]       idx
    );
        return word[int'(idx)*CH_W +: CH_W];
    endfunction

endpackage

// File: rtl/power_ch_cmp.sv
// Window comparator plus saturating debounce counter for one channel;
// shared across all channels by the scan index in the top level.
module power_ch_cmp
    import power_mon_pkg::*;
#(
    parameter int DEB_CNT = 3
) (
    input  logic [CH_W-1:0]  value_i,
    input  logic [CH_W-1:0]  th_low_i,
    input  logic [CH_W-1:0]  th_high_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             alarm_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             alarm_o
);

    localparam logic [CNT_W-1:0] DEB = CNT_W'(DEB_CNT);

    logic out_of_range;
    logic [CNT_W-1:0] cnt_sat;

    // An inverted window (low > high) makes every value fail one of the tests.
    assign out_of_range = (value_i < th_low_i) || (value_i > th_high_i);
    assign cnt_sat      = (cnt_i >= DEB) ? DEB : cnt_i + 1'b1;

    always_comb begin
        cnt_o   = cnt_i;
        alarm_o = alarm_i;
        if (!en_i) begin
            cnt_o   = '0;
            alarm_o = 1'b0;
        end else if (out_of_range) begin
            cnt_o = cnt_sat;
            if (cnt_sat == DEB) begin
                alarm_o = 1'b1;
            end
        end else begin
            cnt_o = '0;
        end
    end

endmodule

// File: rtl/power_alarm_ctrl.sv
// Threshold alarm stage: detects monitor word updates, scans the six
// channels one per cycle against a snapshotted window and keeps sticky alarms.
module power_alarm_ctrl
    import power_mon_pkg::*;
#(
    parameter int DEB_CNT = 3
) (
    input  logic                     sclk,
    input  logic                     rst_n,
    input  logic [CH_NUM*CH_W-1:0]   data_ov,
    input  logic [CH_W-1:0]          th_low,
    input  logic [CH_W-1:0]          th_high,
    input  logic [CH_NUM-1:0]        ch_en,
    input  logic                     alarm_clr,
    output logic [CH_NUM-1:0]        alarm_st,
    output logic                     alarm_irq,
    output logic                     busy,
    output logic [15:0]              scan_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH_NUM - 1);

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [CH_NUM*CH_W-1:0]         data_q;
    logic [CH_NUM*CH_W-1:0]         snap_data_q, snap_data_d;
    logic [CH_W-1:0]                snap_low_q, snap_low_d;
    logic [CH_W-1:0]                snap_high_q, snap_high_d;
    logic [CH_NUM-1:0]              snap_en_q, snap_en_d;
    logic                           pend_q, pend_d;
    logic [CH_NUM-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [CH_NUM-1:0]              alarm_q, alarm_d;
    logic                           rose_q, rose_d;
    logic                           irq_q, irq_d;
    logic                           busy_q, busy_d;
    logic [15:0]                    scan_cnt_q, scan_cnt_d;

    logic                           update;
    logic                           load;
    logic [CNT_W-1:0]               cmp_cnt;
    logic                           cmp_alarm;

    assign update = (data_ov != data_q);

    power_ch_cmp #(
        .DEB_CNT (DEB_CNT)
    ) u_cmp (
        .value_i   (ch_slice(snap_data_q, idx_q)),
        .th_low_i  (snap_low_q),
        .th_high_i (snap_high_q),
        .en_i      (snap_en_q[idx_q]),
        .cnt_i     (cnt_q[idx_q]),
        .alarm_i   (alarm_q[idx_q]),
        .cnt_o     (cmp_cnt),
        .alarm_o   (cmp_alarm)
    );

    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        snap_data_d = snap_data_q;
        snap_low_d  = snap_low_q;
        snap_high_d = snap_high_q;
        snap_en_d   = snap_en_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        alarm_d     = alarm_q;
        rose_d      = rose_q;
        irq_d       = 1'b0;
        scan_cnt_d  = scan_cnt_q;
        busy_d      = (state_q != IDLE) || update;
        load        = 1'b0;

        // The clear lands first so a same-edge evaluation overrides its own channel.
        if (alarm_clr) begin
            cnt_d   = '0;
            alarm_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (update) begin
                    load    = 1'b1;
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                cnt_d[idx_q]   = cmp_cnt;
                alarm_d[idx_q] = cmp_alarm;
                if (cmp_alarm && !alarm_q[idx_q]) begin
                    rose_d = 1'b1;
                end
                if (update) begin
                    pend_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                scan_cnt_d = scan_cnt_q + 16'd1;
                irq_d      = rose_q;
                if (pend_q || update) begin
                    load    = 1'b1;
                    pend_d  = 1'b0;
                    state_d = SCAN;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            snap_data_d = data_ov;
            snap_low_d  = th_low;
            snap_high_d = th_high;
            snap_en_d   = ch_en;
            rose_d      = 1'b0;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            data_q      <= '0;
            snap_data_q <= '0;
            snap_low_q  <= '0;
            snap_high_q <= '0;
            snap_en_q   <= '0;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            alarm_q     <= '0;
            rose_q      <= 1'b0;
            irq_q       <= 1'b0;
            busy_q      <= 1'b0;
            scan_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            data_q      <= data_ov;
            snap_data_q <= snap_data_d;
            snap_low_q  <= snap_low_d;
            snap_high_q <= snap_high_d;
            snap_en_q   <= snap_en_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            alarm_q     <= alarm_d;
            rose_q      <= rose_d;
            irq_q       <= irq_d;
            busy_q      <= busy_d;
            scan_cnt_q  <= scan_cnt_d;
        end
    end

    assign alarm_st  = alarm_q;
    assign alarm_irq = irq_q;
    assign busy      = busy_q;
    assign scan_cnt  = scan_cnt_q;

endmodule

// File: tb/tb_power_alarm_ctrl.sv
// Randomized bench for power_alarm_ctrl: a timeline-based reference model
// checked every cycle, plus directed scenarios with fixed expected values.
module tb_power_alarm_ctrl;

    localparam int DEB = 3;

    logic        sclk;
    logic        rst_n;
    logic [95:0] data_ov;
    logic [15:0] th_low;
    logic [15:0] th_high;
    logic [5:0]  ch_en;
    logic        alarm_clr;
    logic [5:0]  alarm_st;
    logic        alarm_irq;
    logic        busy;
    logic [15:0] scan_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_seen = 0;
    int irq_seen  = 0;

    power_alarm_ctrl #(.DEB_CNT(DEB)) dut (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .data_ov   (data_ov),
        .th_low    (th_low),
        .th_high   (th_high),
        .ch_en     (ch_en),
        .alarm_clr (alarm_clr),
        .alarm_st  (alarm_st),
        .alarm_irq (alarm_irq),
        .busy      (busy),
        .scan_cnt  (scan_cnt)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A scan is a timeline: channel i is judged i+1 edges after the snapshot,
    // and the scan completes 7 edges after it.
    logic [95:0] m_prev, m_snap;
    logic [15:0] m_lo, m_hi;
    logic [5:0]  m_en;
    logic        m_active, m_pend, m_rose, m_irq, m_busy;
    int          m_age;
    int          m_cnt [6];
    logic [5:0]  m_alarm;
    logic [15:0] m_scans;

    task automatic m_start();
        m_active = 1'b1;
        m_age    = 0;
        m_snap   = data_ov;
        m_lo     = th_low;
        m_hi     = th_high;
        m_en     = ch_en;
        m_pend   = 1'b0;
        m_rose   = 1'b0;
    endtask

    always @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev = '0; m_snap = '0; m_lo = '0; m_hi = '0; m_en = '0;
            m_active = 1'b0; m_pend = 1'b0; m_rose = 1'b0; m_irq = 1'b0; m_busy = 1'b0;
            m_age = 0; m_alarm = '0; m_scans = '0;
            for (int i = 0; i < 6; i++) m_cnt[i] = 0;
        end else begin
            automatic logic upd = (data_ov != m_prev);
            automatic logic was_active = m_active;
            automatic int   ev = -1;
            automatic logic [15:0] v;
            m_irq = 1'b0;
            if (m_active) begin
                m_age++;
                if (m_age <= 6) ev = m_age - 1;
            end
            if (alarm_clr) begin
                for (int i = 0; i < 6; i++) begin
                    if (i != ev) begin
                        m_cnt[i]   = 0;
                        m_alarm[i] = 1'b0;
                    end
                end
            end
            if (ev >= 0) begin
                v = m_snap[16*ev +: 16];
                if (!m_en[ev]) begin
                    m_cnt[ev]   = 0;
                    m_alarm[ev] = 1'b0;
                end else if (v < m_lo || v > m_hi) begin
                    if (m_cnt[ev] < DEB) m_cnt[ev]++;
                    if (m_cnt[ev] == DEB) begin
                        if (!m_alarm[ev]) m_rose = 1'b1;
                        m_alarm[ev] = 1'b1;
                    end
                end else begin
                    m_cnt[ev] = 0;
                end
            end
            if (m_active && m_age == 7) begin
                m_scans++;
                m_irq = m_rose;
                if (m_pend || upd) m_start();
                else m_active = 1'b0;
            end else if (m_active) begin
                if (upd) m_pend = 1'b1;
            end else if (upd) begin
                m_start();
            end
            m_busy = was_active || upd;
            m_prev = data_ov;
        end
    end

    always @(negedge sclk) begin
        check("alarm_st", 32'(alarm_st), 32'(m_alarm));
        check("alarm_irq", 32'(alarm_irq), 32'(m_irq));
        check("busy", 32'(busy), 32'(m_busy));
        check("scan_cnt", 32'(scan_cnt), 32'(m_scans));
        if (busy) busy_seen++;
        if (alarm_irq) irq_seen++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic clr_pulse();
        alarm_clr = 1'b1;
        tick();
        alarm_clr = 1'b0;
    endtask

    function automatic logic [95:0] word6(input logic [15:0] c0, c1, c2, c3, c4, c5);
        return {c5, c4, c3, c2, c1, c0};
    endfunction

    function automatic logic [15:0] rnd_val();
        case ($urandom_range(0, 6))
            0: return 16'd99;
            1: return 16'd100;
            2: return 16'd1000;
            3: return 16'd1001;
            4: return 16'($urandom_range(0, 3000));
            5: return 16'd2000;
            default: return 16'd500;
        endcase
    endfunction

    logic [15:0] sc0;

    initial begin
        rst_n = 1'b0;
        data_ov = '0;
        th_low = 16'd100;
        th_high = 16'd1000;
        ch_en = 6'h3F;
        alarm_clr = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // 1: single in-range scan
        busy_seen = 0;
        irq_seen  = 0;
        data_ov = word6(500, 500, 500, 500, 500, 500);
        tick(12);
        check("s1_busy_cycles", 32'(busy_seen), 32'd8);
        check("s1_irq_count", 32'(irq_seen), 32'd0);
        check("s1_scan_cnt", 32'(scan_cnt), 32'd1);
        check("s1_alarm_st", 32'(alarm_st), 32'd0);

        // 2: ch2 high and ch0 low for three distinct updates
        data_ov = word6(99, 501, 1001, 500, 501, 500);
        tick(12);
        data_ov = word6(99, 500, 1001, 501, 500, 501);
        tick(12);
        irq_seen = 0;
        data_ov = word6(99, 501, 1001, 500, 501, 500);
        tick(12);
        check("s2_alarm_st", 32'(alarm_st), 32'h05);
        check("s2_irq_count", 32'(irq_seen), 32'd1);

        // 3: in-range boundary 1000 resets the debounce
        clr_pulse();
        data_ov = word6(500, 1001, 500, 500, 500, 500); tick(12);
        data_ov = word6(500, 1002, 500, 500, 500, 500); tick(12);
        data_ov = word6(500, 1000, 500, 500, 500, 500); tick(12);
        data_ov = word6(500, 1001, 500, 500, 500, 500); tick(12);
        data_ov = word6(500, 1002, 500, 500, 500, 500); tick(12);
        check("s3_alarm_st", 32'(alarm_st), 32'd0);

        // 4: three updates inside one scan collapse into one rescan
        sc0 = scan_cnt;
        data_ov = word6(500, 501, 500, 500, 500, 500); tick(3);
        data_ov = word6(500, 502, 500, 500, 500, 500); tick(2);
        data_ov = word6(500, 503, 500, 500, 500, 2000);
        tick(20);
        check("s4_scan_delta", 32'(scan_cnt - sc0), 32'd2);

        // 5: alarm_clr on the edge where ch2 reaches DEB_CNT
        clr_pulse();
        data_ov = word6(99, 500, 500, 500, 500, 500); tick(12);
        data_ov = word6(99, 501, 1001, 500, 500, 500); tick(12);
        data_ov = word6(99, 500, 1001, 500, 500, 500); tick(12);
        check("s5_pre_alarm", 32'(alarm_st), 32'h01);
        data_ov = word6(99, 501, 1001, 500, 500, 500);
        tick(3);
        alarm_clr = 1'b1;
        tick();
        alarm_clr = 1'b0;
        tick(10);
        check("s5_alarm_st", 32'(alarm_st), 32'h04);

        // 6: inverted window, only ch0 enabled, then reset mid-scan
        clr_pulse();
        th_low = 16'd2000;
        th_high = 16'd1000;
        ch_en = 6'h01;
        data_ov = word6(500, 500, 500, 500, 500, 500); tick(12);
        data_ov = word6(501, 500, 500, 500, 500, 500); tick(12);
        data_ov = word6(500, 500, 500, 500, 500, 500); tick(12);
        check("s6_alarm_st", 32'(alarm_st), 32'h01);
        data_ov = word6(501, 500, 500, 500, 500, 500);
        tick(3);
        @(posedge sclk);
        rst_n = 1'b0;
        @(negedge sclk);
        check("s6_rst_alarm", 32'(alarm_st), 32'd0);
        check("s6_rst_irq", 32'(alarm_irq), 32'd0);
        check("s6_rst_busy", 32'(busy), 32'd0);
        check("s6_rst_scan_cnt", 32'(scan_cnt), 32'd0);
        tick(2);
        rst_n = 1'b1;
        th_low = 16'd100;
        th_high = 16'd1000;
        ch_en = 6'h3F;
        tick(12);

        // 7: randomized traffic against the model
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 7) != 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    data_ov[16*$urandom_range(0, 5) +: 16] = rnd_val();
                end else begin
                    data_ov = word6(rnd_val(), rnd_val(), rnd_val(), rnd_val(), rnd_val(), rnd_val());
                end
            end
            if ($urandom_range(0, 9) == 0) begin
                th_low  = 16'($urandom_range(0, 1500));
                th_high = 16'($urandom_range(500, 2500));
            end else if ($urandom_range(0, 4) == 0) begin
                th_low  = 16'd100;
                th_high = 16'd1000;
            end
            if ($urandom_range(0, 9) == 0) begin
                ch_en = ($urandom_range(0, 1) == 0) ? 6'h3F : 6'($urandom_range(0, 63));
            end
            for (int c = 0; c < int'($urandom_range(1, 12)); c++) begin
                alarm_clr = ($urandom_range(0, 19) == 0);
                tick();
            end
            alarm_clr = 1'b0;
        end
        tick(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
